// File: rtl/shift_unit_arbiter_if.sv
// Request/response bundle between up to NREQ requesters and the shared shifter.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
interface shift_unit_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_op;
  logic [5*NREQ-1:0]  req_amt;
  logic [32*NREQ-1:0] req_data;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_data;

  modport master (
    output req_valid, req_op, req_amt, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_amt, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit barrel shifter (SLL/SRL/SRA/ROR)
// between NREQ requesters, with a single registered result stage.
module shift_unit_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_unit_arbiter_if.slave  bus,
  output logic [IDW-1:0]       rr_ptr
);

  logic           can_accept;
  logic           grant_found;
  logic [IDW-1:0] grant;
  logic           accept;
  int             cand;

  logic [31:0]    op_data;
  logic [1:0]     op_code;
  logic [4:0]     op_amt;
  logic [31:0]    s1, s2, s3, s4, s5;

  logic           resp_valid_q;
  logic [IDW-1:0] resp_id_q;
  logic [31:0]    resp_data_q;

  assign can_accept = !resp_valid_q || bus.resp_ready;

  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant       = cand[IDW-1:0];
      end
    end
  end

  assign accept = !rst && can_accept && grant_found;

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = accept && (grant == IDW'(i));
    end
  end

  assign op_data = bus.req_data[32*grant +: 32];
  assign op_code = bus.req_op[2*grant +: 2];
  assign op_amt  = bus.req_amt[5*grant +: 5];

  // One mux stage of the log shifter: shift by sh when en, else pass through.
  function automatic logic [31:0] shift_stage(input logic [31:0] x, input logic [1:0] op,
                                              input logic en, input int sh);
    logic [63:0] wide;
    logic [31:0] r;
    wide = {x, x} >> sh;
    r    = x;
    if (en) begin
      unique case (op)
        2'b00:   r = x << sh;
        2'b01:   r = x >> sh;
        2'b10:   r = 32'($signed(x) >>> sh);
        default: r = wide[31:0];
      endcase
    end
    return r;
  endfunction

  assign s1 = shift_stage(op_data, op_code, op_amt[0], 1);
  assign s2 = shift_stage(s1,      op_code, op_amt[1], 2);
  assign s3 = shift_stage(s2,      op_code, op_amt[2], 4);
  assign s4 = shift_stage(s3,      op_code, op_amt[3], 8);
  assign s5 = shift_stage(s4,      op_code, op_amt[4], 16);

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      rr_ptr       <= '0;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      resp_id_q    <= grant;
      resp_data_q  <= s5;
      rr_ptr       <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
    end else if (bus.resp_ready) begin
      // Drained with nothing to refill: id/data keep their last values.
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Bench for shift_unit_arbiter: directed cases plus random traffic against a
// cycle model of grant/ready and a shift reference feeding a result queue.
module tb_shift_unit_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic           clk;
  logic           rst;
  logic [IDW-1:0] rr_ptr;

  shift_unit_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus();

  shift_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .rr_ptr (rr_ptr)
  );

  int checks;
  int failures;
  logic [IDW+31:0] exp_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [4:0] a,
                                            input logic [31:0] x);
    logic [31:0] r;
    r = x;
    for (int k = 0; k < int'(a); k++) begin
      case (op)
        2'b00:   r = {r[30:0], 1'b0};
        2'b01:   r = {1'b0, r[31:1]};
        2'b10:   r = {r[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    end
    return r;
  endfunction

  // reference model of the output register and round-robin pointer
  logic            m_valid;
  logic [IDW-1:0]  m_ptr;
  logic [NREQ-1:0] m_ready;
  logic [NREQ-1:0] acc_last;
  logic            m_found;
  int              m_g;
  int              m_idx;
  logic [IDW+31:0] m_e;

  initial begin
    m_valid  = 1'b0;
    m_ptr    = '0;
    acc_last = '0;
  end

  always @(negedge clk) begin
    check("resp_valid", 64'(bus.resp_valid), 64'(m_valid));
    check("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
    m_found = 1'b0;
    m_g     = 0;
    for (int k = 0; k < NREQ; k++) begin
      m_idx = (int'(m_ptr) + k) % NREQ;
      if (!m_found && bus.req_valid[m_idx]) begin
        m_found = 1'b1;
        m_g     = m_idx;
      end
    end
    m_ready = '0;
    if (!rst && (!m_valid || bus.resp_ready) && m_found) m_ready[m_g] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(m_ready));
    acc_last = bus.req_valid & bus.req_ready;
    if (rst) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_ptr   = '0;
    end else begin
      if (m_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 64'(exp_q.size()), 64'd1);
        end else begin
          m_e = exp_q.pop_front();
          check("resp_id", 64'(bus.resp_id), 64'(m_e[IDW+31:32]));
          check("resp_data", 64'(bus.resp_data), 64'(m_e[31:0]));
        end
      end
      if (m_ready != '0) begin
        exp_q.push_back({IDW'(m_g), ref_shift(bus.req_op[2*m_g +: 2], bus.req_amt[5*m_g +: 5],
                                              bus.req_data[32*m_g +: 32])});
        m_valid = 1'b1;
        m_ptr   = IDW'((m_g + 1) % NREQ);
      end else if (bus.resp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic drive_req(input int i, input logic v, input logic [1:0] op,
                           input logic [4:0] amt, input logic [31:0] d);
    bus.req_valid[i]        = v;
    bus.req_op[2*i +: 2]    = op;
    bus.req_amt[5*i +: 5]   = amt;
    bus.req_data[32*i +: 32] = d;
  endtask

  task automatic send(input int i, input logic [1:0] op, input logic [4:0] amt,
                      input logic [31:0] d);
    int n;
    n = 0;
    drive_req(i, 1'b1, op, amt, d);
    @(negedge clk);
    while (!bus.req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 64'(bus.req_ready[i]), 64'd1);
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  logic [31:0] t2_exp [0:3];
  logic        prev_g;
  logic        cur_g;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_amt    = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_id", 64'(bus.resp_id), 64'd0);
    check("rst_resp_data", 64'(bus.resp_data), 64'd0);
    rst = 1'b0;

    // single SRA request
    send(0, 2'b10, 5'd4, 32'h8000_00F0);
    check("t1_valid", 64'(bus.resp_valid), 64'd1);
    check("t1_id", 64'(bus.resp_id), 64'd0);
    check("t1_data", 64'(bus.resp_data), 64'hF800_000F);

    // every op with amount 1 and amount 0
    t2_exp[0] = 32'h0000_0002;
    t2_exp[1] = 32'h4000_0000;
    t2_exp[2] = 32'hC000_0000;
    t2_exp[3] = 32'hC000_0000;
    for (int op = 0; op < 4; op++) begin
      send(0, 2'(op), 5'd1, 32'h8000_0001);
      check("t2_amt1", 64'(bus.resp_data), 64'(t2_exp[op]));
      send(0, 2'(op), 5'd0, 32'h8000_0001);
      check("t2_amt0", 64'(bus.resp_data), 64'h8000_0001);
    end

    // both requesters valid: grants must alternate
    drive_req(0, 1'b1, 2'b00, 5'd8, 32'h0000_00AB);
    drive_req(1, 1'b1, 2'b11, 5'd8, 32'h0000_00CD);
    prev_g = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cur_g = bus.req_ready[1];
      check("t3_one_ready", 64'(bus.req_ready[0] ^ bus.req_ready[1]), 64'd1);
      if (k > 0) check("t3_alternate", 64'(cur_g), 64'(!prev_g));
      prev_g = cur_g;
    end
    @(posedge clk); #1;
    bus.req_valid = '0;

    // backpressure holds the result and blocks new grants
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    send(0, 2'b00, 5'd3, 32'h0000_0001);
    drive_req(1, 1'b1, 2'b01, 5'd4, 32'hF000_0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_blocked", 64'(bus.req_ready), 64'd0);
      check("t4_hold_data", 64'(bus.resp_data), 64'h0000_0008);
      check("t4_hold_id", 64'(bus.resp_id), 64'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("t4_refill_ready", 64'(bus.req_ready), 64'b10);
    @(posedge clk); #1;
    bus.req_valid = '0;
    check("t4_new_id", 64'(bus.resp_id), 64'd1);
    check("t4_new_data", 64'(bus.resp_data), 64'h0F00_0000);

    // reset while a result is held and req1 is pending
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    send(0, 2'b01, 5'd1, 32'h0000_0010);
    drive_req(1, 1'b1, 2'b00, 5'd1, 32'h0000_0001);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_valid_cleared", 64'(bus.resp_valid), 64'd0);
    check("t5_ptr_cleared", 64'(rr_ptr), 64'd0);
    drive_req(0, 1'b1, 2'b00, 5'd2, 32'h0000_0003);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("t5_grant_req0", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1;
    bus.req_valid = '0;

    // random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || acc_last[i]) begin
          drive_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 31)), $urandom);
        end
      end
      bus.resp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
